// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding-mux select codes, the hard-wired
// zero register, and the shadow-entry type that tracks destination metadata
// for instructions in ID/EX, EX/MEM and MEM/WB.
package pipe_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [1:0] FWD_REGFILE = 2'd0;
    localparam logic [1:0] FWD_EXMEM   = 2'd1;
    localparam logic [1:0] FWD_MEMWB   = 2'd2;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] dest;
        logic                 reg_write;
        logic                 mem_read;
    } shadow_entry_t;

    localparam shadow_entry_t SHADOW_EMPTY = '0;

    // An entry can only feed a consumer if it really writes a non-zero register.
    function automatic logic entry_live(shadow_entry_t e);
        return e.valid && e.reg_write && (e.dest != REG_ZERO);
    endfunction

    // True when entry e will produce the value of register r.
    function automatic logic entry_hits(shadow_entry_t e, logic [REG_IDX_W-1:0] r);
        return entry_live(e) && (e.dest == r);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Decode-stage fields and pipeline control in, forwarding selects and
// stall/bubble controls out. The pipeline is the master, the hazard unit
// is the slave.
interface fwd_hazard_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] id_dest;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             flush;
    logic             freeze;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             stall;
    logic             bubble;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_dest, id_reg_write, id_mem_read,
        output flush, freeze,
        input  fwd_a, fwd_b, stall, bubble, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_dest, id_reg_write, id_mem_read,
        input  flush, freeze,
        output fwd_a, fwd_b, stall, bubble, stall_count
    );
endinterface

// File: rtl/fwd_shadow_stage.sv
// One shadow pipeline register holding destination metadata. Holds while
// load is low; when loading, clear substitutes an empty (invalid) entry.
module fwd_shadow_stage
    import pipe_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic          clear,
    input  shadow_entry_t d,
    output shadow_entry_t q
);

    // Capture the upstream entry (or an empty one) on each unfrozen edge.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignment so every shadow stage samples its
        // predecessor's old value and the chain shifts cleanly on one edge.
        if (reset) begin
            q <= SHADOW_EMPTY;
        end else if (load) begin
            q <= clear ? SHADOW_EMPTY : d;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller for the five-stage pipeline.
// Tracks producers in a private three-deep shadow pipeline, derives EX
// forwarding selects one cycle ahead, and raises stall/bubble on load-use.
module fwd_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
)
(
    input logic              clock,
    input logic              reset,
    fwd_hazard_unit_if.slave bus
);

    localparam int N_STAGES = 3;

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    shadow_entry_t    id_entry;

    // Index 0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB.
    shadow_entry_t    shadow_q [N_STAGES];
    shadow_entry_t    shadow_d [N_STAGES];

    logic             hazard;
    logic             stall_c;
    logic             bubble_c;
    logic [1:0]       next_a;
    logic [1:0]       next_b;
    logic [1:0]       fwd_a_q;
    logic [1:0]       fwd_b_q;
    logic [CNT_W-1:0] count_q;

    assign id_rs = bus.id_rs;
    assign id_rt = bus.id_rt;

    // Metadata the ID instruction leaves behind when it moves into EX.
    assign id_entry = '{valid:     bus.id_valid,
                        dest:      bus.id_dest,
                        reg_write: bus.id_reg_write,
                        mem_read:  bus.id_mem_read};

    // Load-use detection; flush squashes the consumer, freeze suppresses both.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        hazard   = 1'b0;
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        hazard   = bus.id_valid && shadow_q[0].mem_read &&
                   (entry_hits(shadow_q[0], id_rs) || entry_hits(shadow_q[0], id_rt));
        if (!bus.freeze) begin
            stall_c  = hazard && !bus.flush;
            bubble_c = hazard || bus.flush;
        end
    end

    // Next forwarding selects: the newest producer (ID/EX, moving to EX/MEM) wins.
    always_comb begin
        next_a = FWD_REGFILE;
        next_b = FWD_REGFILE;
        if (entry_hits(shadow_q[0], id_rs))      next_a = FWD_EXMEM;
        else if (entry_hits(shadow_q[1], id_rs)) next_a = FWD_MEMWB;
        if (entry_hits(shadow_q[0], id_rt))      next_b = FWD_EXMEM;
        else if (entry_hits(shadow_q[1], id_rt)) next_b = FWD_MEMWB;
    end

    // Shadow chain inputs: ID fields feed stage 0, each later stage its predecessor.
    always_comb begin
        shadow_d[0] = id_entry;
        for (int i = 1; i < N_STAGES; i++) begin
            shadow_d[i] = shadow_q[i-1];
        end
    end

    for (genvar i = 0; i < N_STAGES; i++) begin : g_shadow
        fwd_shadow_stage u_stage (
            .clock (clock),
            .reset (reset),
            .load  (!bus.freeze),
            .clear ((i == 0) ? bubble_c : 1'b0),
            .d     (shadow_d[i]),
            .q     (shadow_q[i])
        );
    end

    // Registered forwarding selects, zeroed for the bubble entering EX.
    always_ff @(posedge clock) begin
        if (reset) begin
            fwd_a_q <= FWD_REGFILE;
            fwd_b_q <= FWD_REGFILE;
        end else if (!bus.freeze) begin
            fwd_a_q <= bubble_c ? FWD_REGFILE : next_a;
            fwd_b_q <= bubble_c ? FWD_REGFILE : next_b;
        end
    end

    // Saturating load-use stall counter; stall is already zero while frozen.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (stall_c && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign bus.fwd_a       = fwd_a_q;
    assign bus.fwd_b       = fwd_b_q;
    assign bus.stall       = stall_c;
    assign bus.bubble      = bubble_c;
    assign bus.stall_count = count_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed instruction sequences
// followed by randomized traffic, all compared against an instruction-level
// model of which older in-flight instruction produces each source register.
module tb_fwd_hazard_unit;

    localparam int REG_W  = 5;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    fwd_hazard_unit_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    fwd_hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: the instructions currently past ID, youngest first.
    typedef struct {
        bit valid;
        int dest;
        bit writes;
        bit load;
    } instr_t;

    instr_t in_flight [3];
    int     exp_a;
    int     exp_b;
    int     exp_count;
    bit     exp_stall;
    bit     exp_bubble;
    logic   smp_stall;
    logic   smp_bubble;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic bit produces(instr_t ins, int r);
        return ins.valid && ins.writes && ins.dest != 0 && ins.dest == r;
    endfunction

    // Forwarding source = age of the youngest older instruction writing r.
    function automatic int source_for(int r);
        for (int age = 0; age < 2; age++) begin
            if (produces(in_flight[age], r)) return age + 1;
        end
        return 0;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) in_flight[i] = '{0, 0, 0, 0};
        exp_a     = 0;
        exp_b     = 0;
        exp_count = 0;
    endfunction

    // One clock cycle: drive ID, check combinational controls, clock, check state.
    task automatic cycle(input bit rst, input bit frz, input bit fl, input bit v,
                         input int rs, input int rt, input int dest,
                         input bit rw, input bit mr);
        bit hz;
        reset            = rst;
        bus.freeze       = frz;
        bus.flush        = fl;
        bus.id_valid     = v;
        bus.id_rs        = REG_W'(rs);
        bus.id_rt        = REG_W'(rt);
        bus.id_dest      = REG_W'(dest);
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        #1;
        hz         = v && in_flight[0].load && (produces(in_flight[0], rs) || produces(in_flight[0], rt));
        exp_stall  = !frz && !fl && hz;
        exp_bubble = !frz && (fl || hz);
        smp_stall  = bus.stall;
        smp_bubble = bus.bubble;
        check("stall", smp_stall, exp_stall);
        check("bubble", smp_bubble, exp_bubble);
        @(posedge clock);
        #1;
        if (rst) begin
            model_clear();
        end else if (!frz) begin
            if (exp_stall && exp_count < CNT_MAX) exp_count++;
            exp_a = exp_bubble ? 0 : source_for(rs);
            exp_b = exp_bubble ? 0 : source_for(rt);
            in_flight[2] = in_flight[1];
            in_flight[1] = in_flight[0];
            in_flight[0] = exp_bubble ? '{0, 0, 0, 0} : '{v, dest, rw, mr};
        end
        check("fwd_a", bus.fwd_a, exp_a);
        check("fwd_b", bus.fwd_b, exp_b);
        check("stall_count", bus.stall_count, exp_count);
    endtask

    task automatic alu(input int rs, input int rt, input int rd);
        cycle(0, 0, 0, 1, rs, rt, rd, 1, 0);
    endtask

    task automatic lw(input int base, input int rt);
        cycle(0, 0, 0, 1, base, rt, rt, 1, 1);
    endtask

    task automatic nop();
        cycle(0, 0, 0, 1, 0, 0, 0, 1, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) nop();
    endtask

    bit r_rst, r_frz, r_fl, r_v, r_rw, r_mr;
    int r_rs, r_rt, r_dest;
    bit prev_hold;

    initial begin
        model_clear();
        reset            = 1'b1;
        bus.freeze       = 1'b0;
        bus.flush        = 1'b0;
        bus.id_valid     = 1'b0;
        bus.id_rs        = '0;
        bus.id_rt        = '0;
        bus.id_dest      = '0;
        bus.id_reg_write = 1'b0;
        bus.id_mem_read  = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("reset_fwd_a", bus.fwd_a, 0);
        check("reset_fwd_b", bus.fwd_b, 0);
        check("reset_count", bus.stall_count, 0);
        check("reset_stall", bus.stall, 0);
        check("reset_bubble", bus.bubble, 0);

        // add $3,$1,$2 ; sub $4,$3,$5 -> EX/MEM forward on A.
        alu(1, 2, 3);
        check("raw1_no_stall", smp_stall, 0);
        alu(3, 5, 4);
        check("raw1_no_stall2", smp_stall, 0);
        check("raw1_fwd_a", bus.fwd_a, 1);
        check("raw1_fwd_b", bus.fwd_b, 0);
        drain();

        // add $3 ; nop ; or $6,$3,$3 -> MEM/WB on both.
        alu(1, 2, 3);
        nop();
        alu(3, 3, 6);
        check("raw2_fwd_a", bus.fwd_a, 2);
        check("raw2_fwd_b", bus.fwd_b, 2);
        drain();

        // add $3 ; add $3 ; or $6,$3,$0 -> newest producer wins, $0 never forwarded.
        alu(1, 2, 3);
        alu(1, 1, 3);
        alu(3, 0, 6);
        check("prio_fwd_a", bus.fwd_a, 1);
        check("prio_fwd_b", bus.fwd_b, 0);
        drain();

        // lw $7,0($1) ; add $8,$7,$7 -> one stall, then MEM/WB forward.
        lw(1, 7);
        alu(7, 7, 8);
        check("lu_stall", smp_stall, 1);
        check("lu_bubble", smp_bubble, 1);
        check("lu_count", bus.stall_count, 1);
        alu(7, 7, 8);
        check("lu_stall_once", smp_stall, 0);
        check("lu_fwd_a", bus.fwd_a, 2);
        check("lu_fwd_b", bus.fwd_b, 2);
        drain();

        // lw $0 ; add $9,$0,$0 -> no hazard on register 0.
        lw(1, 0);
        alu(0, 0, 9);
        check("r0_stall", smp_stall, 0);
        check("r0_fwd_a", bus.fwd_a, 0);
        check("r0_fwd_b", bus.fwd_b, 0);
        drain();

        // Flush while a load-use hazard is pending.
        lw(1, 7);
        cycle(0, 0, 1, 1, 7, 7, 8, 1, 0);
        check("flush_stall", smp_stall, 0);
        check("flush_bubble", smp_bubble, 1);
        check("flush_count", bus.stall_count, 1);
        alu(7, 7, 8);
        check("flush_s1_empty", smp_stall, 0);
        check("flush_fwd_a", bus.fwd_a, 2);
        drain();

        // Repeated load-use pairs drive the counter into saturation.
        for (int i = 0; i < 16; i++) begin
            lw(1, 7);
            alu(7, 7, 8);
            alu(7, 7, 8);
        end
        check("sat_count", bus.stall_count, CNT_MAX);
        drain();

        // Freeze over a load-use case, release, then reset on the stall cycle.
        lw(1, 7);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 1, 7, 7, 8, 1, 0);
            check("frz_stall", smp_stall, 0);
            check("frz_bubble", smp_bubble, 0);
        end
        cycle(1, 0, 0, 1, 7, 7, 8, 1, 0);
        check("rst_on_stall", smp_stall, 1);
        cycle(0, 0, 0, 1, 7, 7, 8, 1, 0);
        check("post_rst_stall", smp_stall, 0);
        check("post_rst_fwd_a", bus.fwd_a, 0);
        check("post_rst_count", bus.stall_count, 0);

        // Randomized traffic over a small register set to provoke collisions.
        prev_hold = 1'b0;
        r_v = 1; r_rs = 0; r_rt = 0; r_dest = 0; r_rw = 1; r_mr = 0;
        for (int n = 0; n < 600; n++) begin
            r_rst = ($urandom_range(63) == 0);
            r_frz = ($urandom_range(7) == 0);
            r_fl  = ($urandom_range(15) == 0);
            if (!prev_hold) begin
                r_v    = ($urandom_range(7) != 0);
                r_rs   = $urandom_range(3);
                r_rt   = $urandom_range(3);
                r_dest = $urandom_range(3);
                r_rw   = ($urandom_range(3) != 0);
                r_mr   = ($urandom_range(2) == 0);
            end
            cycle(r_rst, r_frz, r_fl, r_v, r_rs, r_rt, r_dest, r_rw, r_mr);
            prev_hold = !r_rst && (exp_stall || r_frz);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Forwarding and load-use hazard controller for the five-stage MIPS32 pipeline. It generates the 2-bit select lines consumed by the 3:1 operand forwarding muxes in EX, plus the stall and bubble controls for PC, IF/ID and ID/EX. It keeps its own shadow pipeline of destination-register metadata, so it needs only decode-stage register fields and global flush/freeze inputs.

## Interface
Parameters:
- REG_W, 5, register-index width
- CNT_W, 32, stall-counter width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_W  source register A of the ID instruction
- id_rt  in  REG_W  source register B of the ID instruction
- id_dest  in  REG_W  resolved destination (rd or rt) of the ID instruction
- id_reg_write  in  1  ID instruction writes the register file
- id_mem_read  in  1  ID instruction is a load
- flush  in  1  branch taken: squash the ID instruction
- freeze  in  1  external memory stall: hold all state
- fwd_a  out  2  rs select for EX: 0 register file, 1 EX/MEM, 2 MEM/WB
- fwd_b  out  2  rt select for EX, same encoding
- stall  out  1  hold PC and IF/ID this cycle
- bubble  out  1  load a NOP into ID/EX at the next edge
- stall_count  out  CNT_W  number of load-use stalls since reset, saturating

## Operation
- Shadow entries S1 (ID/EX), S2 (EX/MEM), S3 (MEM/WB). Each entry holds {valid, dest, reg_write, mem_read}.
- Live entry: valid && reg_write && dest != 0.
- Load-use hazard (combinational): id_valid && S1 is live && S1.mem_read && (S1.dest == id_rs || S1.dest == id_rt). When true, stall = bubble = 1.
- Flush: bubble = 1 and stall = 0. Flush overrides the hazard, because the hazarding instruction is squashed.
- Next-select for A, computed from the ID instruction:
  - 1 if S1 is live and S1.dest == id_rs;
  - else 2 if S2 is live and S2.dest == id_rs;
  - else 0.
  - The newer producer (EX/MEM) always wins.
- Next-select for B: same rule using id_rt.
- On each edge with freeze = 0:
  - S3 <= S2, S2 <= S1.
  - S1 <= ID fields if no bubble; otherwise all-zero, invalid.
  - fwd_a/fwd_b <= the next-selects; forced to 0 when bubble is set.
- With freeze = 1, S1–S3, fwd_a/fwd_b and stall_count all hold.
- stall and bubble are forced to 0 during freeze, so a stall is never double-counted.
- stall_count increments on each unfrozen cycle with stall = 1. It saturates at all-ones.
- Register 0 is never forwarded and never causes a hazard.

## Timing
- Reset (synchronous, highest priority): S1–S3 invalid; fwd_a = fwd_b = 0; stall_count = 0. stall and bubble therefore evaluate to 0.
- fwd_a/fwd_b are registered. They are valid during the cycle the instruction is in EX, one edge after it was in ID.
- stall/bubble are combinational from the ID inputs and S1, in the same cycle.
- A load-use stall lasts exactly one cycle:
  - After the bubble, the load sits in S2.
  - The consumer's next-select resolves to 2 and it proceeds.
- Back-to-back loads into the same register give one stall per dependent consumer, never two consecutive stalls for one consumer.
- A reset asserted mid-stall clears everything at the edge. The next cycle has stall = 0 regardless of the ID inputs held from before.
- Flush and freeze together: freeze wins and nothing changes. The flush is re-sampled when freeze drops.

## Structure
- Shared package pipe_pkg holds:
  - constants FWD_REGFILE = 2'd0, FWD_EXMEM = 2'd1, FWD_MEMWB = 2'd2;
  - REG_ZERO;
  - the packed shadow-entry type {valid, dest, reg_write, mem_read}.
- One sub-module, fwd_shadow_stage: a single shadow entry with load, clear and hold controls, instantiated three times.
- Compare/priority logic and the counter stay in the top level.

## Test plan
- RAW through EX/MEM: `add $3,$1,$2` then `sub $4,$3,$5`. In the sub's EX cycle, fwd_a = 1 and fwd_b = 0; stall is never asserted.
- RAW through MEM/WB with priority:
  - `add $3`; nop; `or $6,$3,$3` gives fwd_a = fwd_b = 2.
  - `add $3`; `add $3`; `or $6,$3,$0` gives fwd_a = 1 (newest producer) and fwd_b = 0.
- Load-use: `lw $7,0($1)` then `add $8,$7,$7`:
  - stall = bubble = 1 for exactly one cycle;
  - stall_count goes from 0 to 1;
  - in the add's EX cycle, fwd_a = fwd_b = 2.
- Register 0: `lw $0` then `add $9,$0,$0` gives stall = 0 and fwd = 0/0.
- Flush during a hazard: `lw $7` in S1, consumer in ID, flush = 1:
  - stall = 0 and bubble = 1;
  - S1 becomes invalid;
  - stall_count is unchanged.
- Freeze and reset:
  - freeze held for 3 cycles during a load-use case: outputs and stall_count hold, and stall is 0;
  - after release, exactly one stall occurs;
  - reset asserted on that stall cycle gives all outputs 0 on the next cycle.
